// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants and helpers for the registered 1-to-4 demultiplexer.
//   NUM_CH     : number of output channels
//   SEL_W      : width of the channel select
//   STAT_W     : width of each per-channel delivery counter (used only when
//                DEMUX_STATS_EN is defined)
//   sel_t      : channel select type
//   sel_decode : one-hot decode of a channel select
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int STAT_W = 8;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NUM_CH-1:0] ch_mask_t;

    // Turns a channel index into a one-hot channel mask.
    function automatic ch_mask_t sel_decode(input sel_t sel);
        ch_mask_t mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
// One output channel of the demultiplexer: a single-entry register with a
// valid flag and a ready/valid handshake towards its sink.
//
// Optional feature (macro DEMUX_STATS_EN): adds a saturating counter of
// completed output transfers.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   load        : an input transfer targets this slot this cycle
//   load_data   : payload to capture when load is high
//   drain_ready : sink accepts data this cycle
//   data        : held payload
//   valid       : slot holds data
//   stat_cnt    : (DEMUX_STATS_EN only) saturating delivery count
// ---------------------------------------------------------------------------
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              drain_ready,
`ifdef DEMUX_STATS_EN
    output logic [STAT_W-1:0] stat_cnt,
`endif
    output logic [WIDTH-1:0]  data,
    output logic              valid
);

    logic drain;

    // An output transfer completes when the slot is full and the sink is ready.
    assign drain = valid && drain_ready;

    // Data/valid register. A load takes priority over a drain so that a slot
    // being emptied and refilled in the same cycle stays valid with the new
    // word, which keeps the channel at one word per cycle. The data register
    // only changes on a load, so it stays stable while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef DEMUX_STATS_EN
    // Delivery counter, saturating at its all-ones value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt <= '0;
        end else if (drain && (stat_cnt != '1)) begin
            stat_cnt <= stat_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/demux_1to4_reg.sv
// ---------------------------------------------------------------------------
// demux_1to4_reg
// Registered 1-to-4 demultiplexer. A word offered on the input is routed to
// the channel selected by in_sel and held there in a one-entry slot until
// that channel's sink takes it. Channels drain independently; a stalled
// channel only blocks inputs addressed to it.
//
// Optional feature (macro DEMUX_STATS_EN): adds port stat_cnt with one
// saturating 8-bit delivery counter per channel.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_data   : input payload, WIDTH bits
//   in_sel    : destination channel 0..3
//   in_valid  : source offers in_data/in_sel
//   in_ready  : block accepts the offer this cycle
//   out_data  : four WIDTH-bit channels, channel 0 in the LSBs
//   out_valid : per-channel slot holds data
//   out_ready : per-channel sink takes data this cycle
//   stat_cnt  : (DEMUX_STATS_EN only) four 8-bit delivery counters
// ---------------------------------------------------------------------------
module demux_1to4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_CH-1:0][WIDTH-1:0]  out_data,
    output logic [NUM_CH-1:0]             out_valid,
`ifdef DEMUX_STATS_EN
    output logic [NUM_CH-1:0][STAT_W-1:0] stat_cnt,
`endif
    input  logic [NUM_CH-1:0]             out_ready
);

    ch_mask_t load_vec;

    // The addressed slot can take a word if it is empty or is being drained
    // this same cycle. in_valid deliberately plays no part here.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

    // Only the addressed slot sees a load, and only on a completed transfer.
    assign load_vec = (in_valid && in_ready) ? sel_decode(in_sel) : '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH       (WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .load        (load_vec[k]),
            .load_data   (in_data),
            .drain_ready (out_ready[k]),
`ifdef DEMUX_STATS_EN
            .stat_cnt    (stat_cnt[k]),
`endif
            .data        (out_data[k]),
            .valid       (out_valid[k])
        );
    end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// ---------------------------------------------------------------------------
// tb_demux_1to4_reg
// Self-checking bench for demux_1to4_reg. A per-channel queue holds the
// words the bench expects each channel to deliver, in order. Words are
// pushed when the bench predicts an input transfer and popped when it
// predicts an output transfer; every cycle the DUT's in_ready, out_valid
// and out_data are compared against the queue contents. Define
// DEMUX_STATS_EN to also exercise the delivery counters.
// ---------------------------------------------------------------------------
module tb_demux_1to4_reg;
    import demux_pkg::*;

    localparam int WIDTH = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [WIDTH-1:0]              in_data;
    logic [SEL_W-1:0]              in_sel;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CH-1:0][WIDTH-1:0]  out_data;
    logic [NUM_CH-1:0]             out_valid;
    logic [NUM_CH-1:0]             out_ready;
`ifdef DEMUX_STATS_EN
    logic [NUM_CH-1:0][STAT_W-1:0] stat_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] sbq [NUM_CH][$];

    demux_1to4_reg #(
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef DEMUX_STATS_EN
        .stat_cnt  (stat_cnt),
`endif
        .out_ready (out_ready)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports any difference.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compares the DUT outputs against the scoreboard for the current inputs.
    task automatic checkOutput();
        for (int k = 0; k < NUM_CH; k++) begin
            check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(sbq[k].size() != 0));
            if (sbq[k].size() != 0)
                check($sformatf("out_data[%0d]", k), 64'(out_data[k]), 64'(sbq[k][0]));
        end
        check("in_ready", 64'(in_ready), 64'((sbq[in_sel].size() == 0) || out_ready[in_sel]));
    endtask

    // Drives one cycle of inputs, checks, updates the scoreboard, and
    // advances to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] sel,
                                 input logic [WIDTH-1:0] d, input logic [NUM_CH-1:0] rdy);
        logic acc;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        #1;
        checkOutput();
        acc = v && ((sbq[sel].size() == 0) || rdy[sel]);
        for (int k = 0; k < NUM_CH; k++) begin
            if ((sbq[k].size() != 0) && rdy[k])
                void'(sbq[k].pop_front());
        end
        if (acc)
            sbq[sel].push_back(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;

        // Reset state
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        #2;
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_out_data", 64'(out_data), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int s = 0; s < NUM_CH; s++) begin
            in_sel = SEL_W'(s);
            #1;
            check($sformatf("post_reset_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end

        // Routing: 0xA5 to channel 3, everything else untouched
        applyStimulus(1'b1, 2'd3, 8'hA5, 4'b1111);
        check("route_out_valid", 64'(out_valid), 64'h8);
        check("route_out_data", 64'(out_data), 64'hA500_0000);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        // Backpressure on channel 1
        applyStimulus(1'b1, 2'd1, 8'h11, 4'b1101);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1101);
        check("bp_in_ready_low", 64'(in_ready), 64'h0);
        check("bp_hold_0x11", 64'(out_data[1]), 64'h11);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1101);
        check("bp_still_0x11", 64'(out_data[1]), 64'h11);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1111);
        check("bp_next_valid", 64'(out_valid[1]), 64'h1);
        check("bp_next_0x22", 64'(out_data[1]), 64'h22);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        // Independence: channel 0 stalled and full, channel 2 still flows
        applyStimulus(1'b1, 2'd0, 8'h44, 4'b1110);
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 8'h33;
        out_ready = 4'b1110;
        #1;
        check("indep_in_ready", 64'(in_ready), 64'h1);
        applyStimulus(1'b1, 2'd2, 8'h33, 4'b1110);
        check("indep_out_valid", 64'(out_valid), 64'h5);
        check("indep_ch2_data", 64'(out_data[2]), 64'h33);
        check("indep_ch0_data", 64'(out_data[0]), 64'h44);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        // Throughput: 16 words on channel 0 in 16 consecutive cycles
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 2'd0, WIDTH'(i), 4'b1111);
            if ((out_valid[0] === 1'b1) && (out_data[0] === WIDTH'(i)))
                seen++;
        end
        check("tput_words_in_order", 64'(seen), 64'd16);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        // Reset mid-stream with slot 2 full
        applyStimulus(1'b1, 2'd2, 8'h5A, 4'b1011);
        check("midrst_slot2_full", 64'(out_valid[2]), 64'h1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        check("midrst_out_data", 64'(out_data), 64'h0);
`ifdef DEMUX_STATS_EN
        check("midrst_stat_cnt", 64'(stat_cnt), 64'h0);
`endif
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 8'h77;
        out_ready = 4'b1111;
        @(posedge clk); #1;
        check("midrst_no_transfer", 64'(out_valid), 64'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            sbq[k].delete();
        #1;
        for (int s = 0; s < NUM_CH; s++) begin
            in_sel = SEL_W'(s);
            #1;
            check($sformatf("midrst_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
        end

`ifdef DEMUX_STATS_EN
        // Statistics: 300 deliveries on channel 1 saturate its counter
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, 2'd1, WIDTH'(i), 4'b1111);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);
        check("stat_cnt_ch1_sat", 64'(stat_cnt[1]), 64'd255);
        check("stat_cnt_all", 64'(stat_cnt), 64'h0000_FF00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to4_reg.md
DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width in bits of the input and of each output channel.
REQ-002 SHALL have port clk  input  1  as the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  as the reset: asynchronous, active-high.
REQ-004 SHALL have port in_data  input  WIDTH  as the input payload.
REQ-005 SHALL have port in_sel  input  2  as the destination channel index, 0..3.
REQ-006 SHALL have port in_valid  input  1  meaning the source offers in_data/in_sel this cycle.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts the offer this cycle.
REQ-008 SHALL have ports out_data  output  4xWIDTH, as a packed array of four WIDTH-bit channels indexed by channel, channel 0 in the LSBs.
REQ-009 SHALL have port out_valid  output  4  with one bit per channel, meaning that channel's register holds data.
REQ-010 SHALL have port out_ready  input  4  with one bit per channel, meaning that channel's sink takes data this cycle.

Function
REQ-011 SHALL hold one WIDTH-bit data register plus a valid flag per channel, so four independent one-entry slots exist.
REQ-012 SHALL complete an input transfer when in_valid && in_ready at a rising clk edge.
REQ-013 SHALL complete an output transfer on channel k when out_valid[k] && out_ready[k] at a rising clk edge.
REQ-014 SHALL drive in_ready = !out_valid[in_sel] || out_ready[in_sel]; in_ready is combinational from in_sel, out_valid and out_ready, and independent of in_valid.
REQ-015 SHALL, on an input transfer, load in_data into slot in_sel and set out_valid[in_sel] at the next edge, giving one-cycle latency.
REQ-016 SHALL leave slots other than in_sel unchanged by an input transfer.
REQ-017 SHALL, on an output transfer on channel k with no simultaneous input transfer to k, clear out_valid[k].
REQ-018 SHALL, when an output transfer and an input transfer hit the same channel in the same cycle, keep out_valid set and load the new data, so the channel sustains full throughput.
REQ-019 SHALL hold out_data[k] stable while out_valid[k]=1 && out_ready[k]=0.
REQ-020 SHALL let channels drain independently; a stalled channel blocks only inputs addressed to it.
REQ-021 SHALL ignore in_data and in_sel while in_valid=0, with no state change.
REQ-022 SHALL never drop or duplicate a word; per-channel order equals input order.

Reset
REQ-023 SHALL, while rst=1, force out_valid=4'b0000 and all out_data to zero immediately, independent of clk.
REQ-024 SHALL discard held data when reset is asserted mid-operation; no transfer completes at an edge where rst=1.
REQ-025 SHALL, after rst is released, drive in_ready=1 for every in_sel.

Configuration
REQ-026 SHALL, with DEMUX_STATS_EN defined, add an output port stat_cnt  4x8, holding one saturating 8-bit counter per channel.
REQ-027 SHALL increment stat_cnt[k] on each output transfer on channel k, hold it at 255 once reached, and reset it to 0 while rst=1.
REQ-028 SHALL, without DEMUX_STATS_EN, omit stat_cnt and its logic entirely.

Structure
REQ-029 SHALL take NUM_CH=4, SEL_W=2 and STAT_W=8 from the shared package demux_pkg.
REQ-030 SHALL implement each channel as sub-module demux_slot (data register, valid flag, optional counter), instantiated four times.

Verification
REQ-031 SHALL cover reset: assert rst mid-stream with slot 2 full -> out_valid=0000 and out_data=0 immediately, and in_ready=1 after release.
REQ-032 SHALL cover routing: send 0xA5 with sel=3 while all out_ready=1 -> the next cycle out_valid=1000 and out_data[3]=0xA5; other channels unchanged.
REQ-033 SHALL cover backpressure: out_ready[1]=0, send 0x11 then 0x22 with sel=1 -> in_ready=0 on the second word and out_data[1] holds 0x11 until out_ready[1] rises, then 0x22 follows.
REQ-034 SHALL cover independence: channel 0 stalled and full, send 0x33 with sel=2 -> accepted with in_ready=1 and delivered on channel 2.
REQ-035 SHALL cover throughput: with out_ready[0]=1, stream 0x00..0x0F on sel=0, one word per cycle -> 16 transfers in 16 consecutive cycles, in order, with no bubbles.
REQ-036 SHALL cover statistics, with DEMUX_STATS_EN defined: deliver 300 words on channel 1 -> stat_cnt[1]=255 and all other counters 0.
